add_sub_align_stage: RTL and testbench

ADD_SUB_ALIGN_STAGE -- requirements
Module: add_sub_align_stage

---
 rtl/add_sub_align_stage.sv | 134 +++++++++++++
 tb/tb_add_sub_align_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/add_sub_align_stage.sv
// ============================================================================
// add_sub_align_stage : FP add/sub front end -- unpack, magnitude compare and
// exponent difference (S1), then sticky-preserving alignment shift (S2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_sub_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  input  logic                   i_add_sub,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_comp_man,
  output logic                   o_sign_man_a,
  output logic                   o_sign_man_b,
  output logic                   o_add_sub,
  output logic                   o_eff_sub,
  output logic [EXP_W-1:0]       o_exp_big,
  output logic [MAN_W+3:0]       o_man_big,
  output logic [MAN_W+3:0]       o_man_small,
  output logic                   o_special
);

  localparam int MW = MAN_W + 4;
  localparam int W  = 1 + EXP_W + MAN_W;

  // ---------------- S1: unpack and compare ----------------
  logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b, diff;
  logic [MW-1:0]    man_a, man_b;
  logic             b_bigger, special, accept, s1_advance;

  assign exp_a  = i_a[MAN_W +: EXP_W];
  assign exp_b  = i_b[MAN_W +: EXP_W];
  // Denormals and zero share the exponent of the smallest normal
  assign eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
  assign eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
  assign man_a  = {|exp_a, i_a[MAN_W-1:0], 3'b000};
  assign man_b  = {|exp_b, i_b[MAN_W-1:0], 3'b000};

  // Ties go to a, so equal magnitudes report comp_man = 0
  assign b_bigger = i_b[W-2:0] > i_a[W-2:0];
  assign diff     = b_bigger ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
  assign special  = (&exp_a) | (&exp_b);

  logic             s1_valid, s2_valid;
  logic             s1_comp, s1_sign_a, s1_sign_b, s1_add_sub, s1_eff_sub, s1_special;
  logic [EXP_W-1:0] s1_exp_big, s1_diff;
  logic [MW-1:0]    s1_man_big, s1_man_small;

  assign s1_advance = !s2_valid || i_ready;
  assign o_ready    = !s1_valid || s1_advance;
  assign accept     = i_valid && o_ready;
  assign o_valid    = s2_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid     <= 1'b0;
      s1_comp      <= 1'b0;
      s1_sign_a    <= 1'b0;
      s1_sign_b    <= 1'b0;
      s1_add_sub   <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_special   <= 1'b0;
      s1_exp_big   <= '0;
      s1_diff      <= '0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
    end else begin
      if (accept) begin
        s1_valid     <= 1'b1;
        s1_comp      <= b_bigger;
        s1_sign_a    <= i_a[W-1];
        s1_sign_b    <= i_b[W-1];
        s1_add_sub   <= i_add_sub;
        s1_eff_sub   <= i_a[W-1] ^ i_b[W-1] ^ i_add_sub;
        s1_special   <= special;
        s1_exp_big   <= b_bigger ? eexp_b : eexp_a;
        s1_diff      <= diff;
        s1_man_big   <= b_bigger ? man_b : man_a;
        s1_man_small <= b_bigger ? man_a : man_b;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------- S2: alignment shift ----------------
  logic [MW-1:0] shifted, lost_mask, aligned;

  // Shifts of MW or more zero the mantissa and leave every bit in the mask,
  // so the sticky bit alone reports a non-zero small operand.
  assign shifted   = s1_man_small >> s1_diff;
  assign lost_mask = ~({MW{1'b1}} << s1_diff);
  assign aligned   = {shifted[MW-1:1], shifted[0] | (|(s1_man_small & lost_mask))};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid     <= 1'b0;
      o_comp_man   <= 1'b0;
      o_sign_man_a <= 1'b0;
      o_sign_man_b <= 1'b0;
      o_add_sub    <= 1'b0;
      o_eff_sub    <= 1'b0;
      o_special    <= 1'b0;
      o_exp_big    <= '0;
      o_man_big    <= '0;
      o_man_small  <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_comp_man   <= s1_comp;
        o_sign_man_a <= s1_sign_a;
        o_sign_man_b <= s1_sign_b;
        o_add_sub    <= s1_add_sub;
        o_eff_sub    <= s1_eff_sub;
        o_special    <= s1_special;
        o_exp_big    <= s1_exp_big;
        o_man_big    <= s1_man_big;
        o_man_small  <= aligned;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_sub_align_stage.sv
// ============================================================================
// tb_add_sub_align_stage : directed vectors, stall and reset checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_add_sub_align_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_add_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_comp_man, o_sign_man_a, o_sign_man_b, o_add_sub, o_eff_sub, o_special;
  logic [7:0]  o_exp_big;
  logic [26:0] o_man_big, o_man_small;

  add_sub_align_stage #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_add_sub(i_add_sub), .o_valid(o_valid), .i_ready(i_ready),
    .o_comp_man(o_comp_man), .o_sign_man_a(o_sign_man_a), .o_sign_man_b(o_sign_man_b),
    .o_add_sub(o_add_sub), .o_eff_sub(o_eff_sub), .o_exp_big(o_exp_big),
    .o_man_big(o_man_big), .o_man_small(o_man_small), .o_special(o_special)
  );

  always #5 i_clk = ~i_clk;

  // Hand-computed vectors: a, b, op -> comp, eff_sub, exp_big, man_big, man_small, special
  logic [31:0] va    [9] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h00000001, 32'h3F800000,
                             32'h40000000, 32'h7F800000, 32'hBF800000, 32'h00000000};
  logic [31:0] vb    [9] = '{32'h40000000, 32'h30800000, 32'hC0400000, 32'h00800000, 32'h3FC00000,
                             32'h3E000001, 32'h3F800000, 32'h3F800000, 32'h80000000};
  logic        vop   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vcomp [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        veff  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0]  vexp  [9] = '{8'h80, 8'h7F, 8'h80, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h7F, 8'h01};
  logic [26:0] vbig  [9] = '{27'h4000000, 27'h4000000, 27'h6000000, 27'h4000000, 27'h6000000,
                             27'h4000000, 27'h4000000, 27'h4000000, 27'h0000000};
  logic [26:0] vsml  [9] = '{27'h2000000, 27'h0000001, 27'h6000000, 27'h0000008, 27'h4000000,
                             27'h0400001, 27'h0000001, 27'h4000000, 27'h0000000};
  logic        vspec [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k);
    i_valid   = 1'b1;
    i_a       = va[k];
    i_b       = vb[k];
    i_add_sub = vop[k];
  endtask

  // One unstalled transaction: accepted at edge 0, o_valid after edge 1
  task automatic run_one(input int k);
    @(negedge i_clk);
    i_ready = 1'b1;
    drive(k);
    #1 chk("accept_ready", o_ready, 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("lat_early", o_valid, 0);
    @(negedge i_clk);
    chk("lat_valid", o_valid, 1);
    chk("comp_man", o_comp_man, vcomp[k]);
    chk("eff_sub", o_eff_sub, veff[k]);
    chk("exp_big", o_exp_big, vexp[k]);
    chk("man_big", o_man_big, vbig[k]);
    chk("man_small", o_man_small, vsml[k]);
    chk("special", o_special, vspec[k]);
    chk("sign_a", o_sign_man_a, va[k][31]);
    chk("sign_b", o_sign_man_b, vb[k][31]);
    chk("add_sub", o_add_sub, vop[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_idx, out_idx, low;

    // Reset state
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_man_big", o_man_big, 0);
    chk("rst_exp_big", o_exp_big, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 chk("rel_ready", o_ready, 1);

    for (int k = 0; k < 9; k++) run_one(k);

    // Back-to-back 4 pairs with the output stalled for 3 cycles
    in_idx = 0; out_idx = 0; low = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
      @(negedge i_clk);
      if (o_valid && low < 3) begin
        i_ready = 1'b0;
        low++;
        #1;
        chk("stall_ready", o_ready, 0);
        chk("stall_hold", o_man_small, vsml[out_idx]);
        chk("stall_hold_exp", o_exp_big, vexp[out_idx]);
      end else begin
        i_ready = (low >= 3);
      end
      if (in_idx < 4) drive(in_idx);
      else i_valid = 1'b0;
      #1;
      if (i_valid && o_ready) in_idx++;
      if (o_valid && i_ready) begin
        chk("stream_exp", o_exp_big, vexp[out_idx]);
        chk("stream_big", o_man_big, vbig[out_idx]);
        chk("stream_small", o_man_small, vsml[out_idx]);
        chk("stream_comp", o_comp_man, vcomp[out_idx]);
        out_idx++;
      end
    end
    chk("stream_count", out_idx, 4);
    chk("stall_cycles", low, 3);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1 chk("stream_drained", o_valid, 0);

    // Reset with both stages occupied
    @(negedge i_clk);
    i_ready = 1'b0;
    drive(0);
    @(negedge i_clk);
    drive(1);
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    chk("full_valid", o_valid, 1);
    chk("full_ready", o_ready, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_man_big", o_man_big, 0);
    chk("async_comp", o_comp_man, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    #1 chk("post_rst_ready", o_ready, 1);
    @(negedge i_clk);
    chk("no_stale", o_valid, 0);
    run_one(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
